// File: rtl/rgb_ball_pkg.sv
// ---------------------------------------------------------------------------
// rgb_ball_pkg
// Shared definitions for the ball-colour sequence transmitter:
//   - 2-bit colour codes (GC/BC/RC, plus NC for "no ball")
//   - FSM state encoding
//   - permutation-index constants and a legality helper
// Optional feature macro used by the top: RGB_GEN_ERR_INJECT_EN
// ---------------------------------------------------------------------------
package rgb_ball_pkg;

  localparam logic [1:0] GC = 2'b00;
  localparam logic [1:0] BC = 2'b01;
  localparam logic [1:0] RC = 2'b10;
  localparam logic [1:0] NC = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] PERM_GBR  = 3'd0;
  localparam logic [2:0] PERM_GRB  = 3'd1;
  localparam logic [2:0] PERM_BGR  = 3'd2;
  localparam logic [2:0] PERM_BRG  = 3'd3;
  localparam logic [2:0] PERM_RGB  = 3'd4;
  localparam logic [2:0] PERM_RBG  = 3'd5;
  localparam logic [2:0] PERM_LAST = PERM_RBG;

  // Indices 6 and 7 have no colour order behind them.
  function automatic logic permLegal(input logic [2:0] sel);
    return (sel <= PERM_LAST);
  endfunction

endpackage

// File: rtl/rgb_perm_lut.sv
// ---------------------------------------------------------------------------
// rgb_perm_lut
// Combinational map from a permutation index to the three colours of a
// triplet, in emission order.
// Ports:
//   perm_sel_i  [2:0]  permutation index (0..5 valid)
//   c1_o        [1:0]  first colour of the triplet
//   c2_o        [1:0]  second colour
//   c3_o        [1:0]  third colour
// Out-of-range indices yield NC on all three outputs.
// ---------------------------------------------------------------------------
module rgb_perm_lut
  import rgb_ball_pkg::*;
(
  input  logic [2:0] perm_sel_i,
  output logic [1:0] c1_o,
  output logic [1:0] c2_o,
  output logic [1:0] c3_o
);

  // One row per legal order; anything else is a "no colour" triplet.
  always_comb begin
    c1_o = NC;
    c2_o = NC;
    c3_o = NC;
    case (perm_sel_i)
      PERM_GBR: begin c1_o = GC; c2_o = BC; c3_o = RC; end
      PERM_GRB: begin c1_o = GC; c2_o = RC; c3_o = BC; end
      PERM_BGR: begin c1_o = BC; c2_o = GC; c3_o = RC; end
      PERM_BRG: begin c1_o = BC; c2_o = RC; c3_o = GC; end
      PERM_RGB: begin c1_o = RC; c2_o = GC; c3_o = BC; end
      PERM_RBG: begin c1_o = RC; c2_o = BC; c3_o = GC; end
      default:  begin c1_o = NC; c2_o = NC; c3_o = NC; end
    endcase
  end

endmodule

// File: rtl/rgb_ball_seq_gen.sv
// ---------------------------------------------------------------------------
// rgb_ball_seq_gen
// Ball-colour sequence transmitter. On a legal start it emits num_trip
// back-to-back triplets (one G, one B, one R each) in the order chosen by
// perm_sel, over a valid/ready colour stream. All outputs are registered.
// Ports:
//   clk       clock (rising edge)
//   rst       synchronous active-high reset
//   start     run request, only looked at in IDLE
//   perm_sel  [2:0] triplet order (0..5)
//   num_trip  [CNT_W-1:0] number of triplets (non-zero)
//   ball_out  [1:0] colour (NC when no valid ball)
//   ball_vld  ball_out holds a ball
//   ball_rdy  consumer takes the ball this cycle
//   busy      run in progress
//   done      one-cycle pulse after the last ball is taken
//   err       one-cycle pulse when a start request is rejected
//   inj       (RGB_GEN_ERR_INJECT_EN only) corrupt the current triplet so
//             that its third ball repeats its first colour
// Optional feature macro: RGB_GEN_ERR_INJECT_EN
// ---------------------------------------------------------------------------
module rgb_ball_seq_gen
  import rgb_ball_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       perm_sel,
  input  logic [CNT_W-1:0] num_trip,
  output logic [1:0]       ball_out,
  output logic             ball_vld,
  input  logic             ball_rdy,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef RGB_GEN_ERR_INJECT_EN
  ,
  input  logic             inj
`endif
);

  state_t           state_q, state_d;
  logic [2:0]       perm_q, perm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ballOut_q, ballOut_d;
  logic             ballVld_q, ballVld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef RGB_GEN_ERR_INJECT_EN
  logic             inj_q, inj_d;
`endif

  logic [2:0] lutSel;
  logic [1:0] c1, c2, c3;
  logic       accept;
  logic       startOk;

  // In IDLE the first ball is prepared from the live perm_sel, since the
  // latched copy only becomes valid on the same edge the ball is registered.
  assign lutSel  = (state_q == IDLE) ? perm_sel : perm_q;
  assign accept  = ballVld_q && ball_rdy;
  assign startOk = start && permLegal(perm_sel) && (num_trip != '0);

  rgb_perm_lut u_lut (
    .perm_sel_i (lutSel),
    .c1_o       (c1),
    .c2_o       (c2),
    .c3_o       (c3)
  );

  // State register plus all registered outputs and run context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      perm_q    <= '0;
      cnt_q     <= '0;
      ballOut_q <= NC;
      ballVld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef RGB_GEN_ERR_INJECT_EN
      inj_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      perm_q    <= perm_d;
      cnt_q     <= cnt_d;
      ballOut_q <= ballOut_d;
      ballVld_q <= ballVld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef RGB_GEN_ERR_INJECT_EN
      inj_q     <= inj_d;
`endif
    end
  end

  // Next-state logic. The triplet count is tested before it is decremented,
  // so it never wraps below one.
  always_comb begin
    state_d = state_q;
    perm_d  = perm_q;
    cnt_d   = cnt_q;
`ifdef RGB_GEN_ERR_INJECT_EN
    inj_d   = inj_q;
`endif
    case (state_q)
      IDLE: begin
        if (startOk) begin
          state_d = S1;
          perm_d  = perm_sel;
          cnt_d   = num_trip;
        end
      end
      S1: begin
        if (accept) begin
          state_d = S2;
`ifdef RGB_GEN_ERR_INJECT_EN
          inj_d   = inj;
`endif
        end
      end
      S2: begin
        if (accept) state_d = S3;
      end
      S3: begin
        if (accept) begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = S1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: outputs are computed for the state being entered and then
  // registered, so a stalled ball is simply recomputed to the same value.
  always_comb begin
    ballOut_d = NC;
    ballVld_d = 1'b0;
    case (state_d)
      S1: begin ballOut_d = c1; ballVld_d = 1'b1; end
      S2: begin ballOut_d = c2; ballVld_d = 1'b1; end
      S3: begin
        ballVld_d = 1'b1;
`ifdef RGB_GEN_ERR_INJECT_EN
        ballOut_d = inj_q ? c1 : c3;
`else
        ballOut_d = c3;
`endif
      end
      default: begin ballOut_d = NC; ballVld_d = 1'b0; end
    endcase
    busy_d = ballVld_d;
    done_d = (state_d == DONE);
    err_d  = (state_q == IDLE) && start && !startOk;
  end

  assign ball_out = ballOut_q;
  assign ball_vld = ballVld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/rgb_ball_seq_gen.md
Name: rgb_ball_seq_gen

Overview:
- Ball-colour sequence transmitter: emits N back-to-back triplets of distinct colours (one G, one B, one R) in a selected order.
- Output is a 2-bit colour stream with a valid/ready handshake.
- It is the sourcing end of the colour-stream interface consumed by the RGB non-overlap Mealy detector.
- Used as a stimulus source and as a sorter-line dispenser model; the detector must assert det on the third ball of every emitted triplet.

Parameters:
- CNT_W, 4: width of the triplet-count input. Maximum run is 2^CNT_W-1 triplets.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a run; sampled only in IDLE
- perm_sel  in  3  triplet order: 0=G,B,R 1=G,R,B 2=B,G,R 3=B,R,G 4=R,G,B 5=R,B,G
- num_trip  in  CNT_W  number of triplets to emit
- ball_out  out  2  colour: 00=G, 01=B, 10=R, 11=none
- ball_vld  out  1  ball_out holds a valid ball
- ball_rdy  in  1  consumer accepts the ball this cycle
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last ball is accepted
- err  out  1  one-cycle pulse when a start request is rejected

Behaviour:
- Clock and reset: clk rising edge; rst synchronous, active-high.
- Reset values: state=IDLE, ball_out=11, ball_vld=0, busy=0, done=0, err=0, count=0, latched selection=0.
- States: IDLE, S1, S2, S3, DONE. All outputs are registered.
- IDLE, legal start (start=1, perm_sel<=5, num_trip!=0):
  - latch perm_sel and num_trip;
  - go to S1;
  - from the next cycle: busy=1, ball_vld=1, ball_out=first colour.
- IDLE, illegal start (perm_sel 6/7 or num_trip=0): err=1 for one cycle; stay in IDLE.
- S1 → S2 → S3: each state advances only on ball_vld&&ball_rdy.
- While ball_rdy=0: ball_out and ball_vld hold stable. Once asserted, vld is never withdrawn before acceptance.
- S3 accepted:
  - if count>1: decrement count, go to S1 (triplets are back-to-back, no gap);
  - else go to DONE.
- DONE: ball_vld=0, ball_out=11, done=1 for one cycle, busy=0. Next state is IDLE.
- Any cycle with ball_vld=0 drives ball_out=11.
- Latency and throughput: start at edge k gives first valid ball in cycle k+1. With rdy held at 1, 3N balls take 3N consecutive cycles and done pulses in the following cycle.
- start outside IDLE (including DONE) is ignored, with no err.
- perm_sel and num_trip changes after latching have no effect on the current run.
- rst mid-run: return to IDLE next edge; no done pulse; the partial triplet is abandoned.
- Colour order is fixed per run. The count decrement never wraps because the count is checked before decrementing.

Optional Feature:
- Macro RGB_GEN_ERR_INJECT_EN.
- When defined:
  - extra input inj (1 bit), sampled when a triplet's S1 ball is accepted;
  - if inj=1 for that triplet, its S3 ball repeats the S1 colour (e.g. G,B,G), so the detector must not fire on that triplet.
- When undefined: no inj port; every triplet is a legal permutation.

Decomposition:
- Package rgb_ball_pkg holds:
  - colour constants GC=00, BC=01, RC=10, NC=11;
  - state encoding;
  - permutation-index constants.
- Sub-module rgb_perm_lut: combinational, maps perm_sel to three 2-bit colours c1/c2/c3. Out-of-range indices return NC,NC,NC; the top never uses these because it rejects the start.

Test Plan:
1. rst, then start with perm_sel=4, num_trip=1, rdy=1 → cycles 1-3 emit 10,00,01 with vld=1; done pulses in cycle 4; busy low after that; ball_out=11 once idle.
2. perm_sel=0, num_trip=3, rdy=1 → 9 consecutive balls 00,01,10 repeated; a detector hookup shows det=1 on balls 3, 6 and 9 only.
3. perm_sel=2, num_trip=2, rdy toggling 1,0,0,1,... → no ball dropped or duplicated; ball_out stable while rdy=0; accepted sequence is 01,00,10,01,00,10.
4. start with perm_sel=6 → err=1 for one cycle, busy=0, vld=0; start with num_trip=0 → same result.
5. rst asserted during the second ball of a 2-triplet run → next cycle vld=0, busy=0, no done; a new start then works normally.
6. RGB_GEN_ERR_INJECT_EN defined, perm_sel=1, num_trip=2, inj=1 on the first triplet only → accepted balls are 00,10,00,00,10,01; detector fires once, on the last ball.
